// File: rtl/fetch_unit_if.sv
// fetch_unit_if: groups the fetch unit's instruction-memory, redirect and
// decode-handshake signals.
//   imem_req/imem_addr    fetch request and byte address   (fetch -> imem)
//   imem_rdata            instruction word, one cycle late  (imem -> fetch)
//   br_taken/br_target    redirect strobe and target        (downstream -> fetch)
//   instr_valid/instr/instr_pc  head of the fetch buffer     (fetch -> decode)
//   instr_ready           decode accepts the head           (decode -> fetch)
// Modports: master = fetch unit side, slave = memory/decode side.
interface fetch_unit_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        br_taken;
    logic [63:0] br_target;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [63:0] instr_pc;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_rdata, br_taken, br_target, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_rdata, br_taken, br_target, instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with a two-entry buffer, one
// outstanding memory request and branch redirect/flush.
// Ports:
//   clk           clock, all state updates on the rising edge
//   reset         synchronous active-high reset
//   bus           fetch_unit_if.master (imem request/response, redirect,
//                 decode handshake)
//   perf_fetched  count of accepted instructions (32-bit, wraps)
//   perf_stall    count of cycles with instr_valid=1 and instr_ready=0
// Optional feature: define FETCH_PERF_EN to build the performance counters;
// otherwise both counter outputs are tied to 0.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus,
    output logic [31:0]  perf_fetched,
    output logic [31:0]  perf_stall
);
    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;
    localparam int unsigned CW   = 32;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [ILEN-1:0] e0_instr_q, e0_instr_d, e1_instr_q, e1_instr_d;
    logic [XLEN-1:0] e0_pc_q, e0_pc_d, e1_pc_q, e1_pc_d;
    logic            v0_q, v0_d, v1_q, v1_d;
    logic            infl_q, infl_d;
    logic [XLEN-1:0] infl_pc_q, infl_pc_d;

    logic            pop;
    logic            push;
    logic            issue;
    logic [1:0]      occ;
    logic            unused_tgt_lsb;

    // Entry 0 is always the head; valid entries are contiguous from entry 0.
    assign pop   = v0_q & bus.instr_ready;
    assign push  = infl_q;
    // Buffered + in-flight after this cycle's pop; cannot underflow since pop needs v0.
    assign occ   = 2'(v0_q) + 2'(v1_q) + 2'(infl_q) - 2'(pop);
    assign issue = ~reset & ~bus.br_taken & (occ < 2'd2);

    assign bus.imem_req    = issue;
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = v0_q;
    assign bus.instr       = e0_instr_q;
    assign bus.instr_pc    = e0_pc_q;

    assign unused_tgt_lsb  = ^bus.br_target[1:0];

    // Next-state: shift on pop, write response into first free slot, issue, redirect.
    always_comb begin
        pc_d       = pc_q;
        e0_instr_d = e0_instr_q;
        e0_pc_d    = e0_pc_q;
        e1_instr_d = e1_instr_q;
        e1_pc_d    = e1_pc_q;
        v0_d       = v0_q;
        v1_d       = v1_q;
        infl_d     = issue;
        infl_pc_d  = infl_pc_q;

        if (pop) begin
            e0_instr_d = e1_instr_q;
            e0_pc_d    = e1_pc_q;
            v0_d       = v1_q;
            v1_d       = 1'b0;
        end

        if (push) begin
            // One entry still occupied after the pop -> the response goes to slot 1.
            if (pop ? v1_q : v0_q) begin
                e1_instr_d = bus.imem_rdata;
                e1_pc_d    = infl_pc_q;
                v1_d       = 1'b1;
            end else begin
                e0_instr_d = bus.imem_rdata;
                e0_pc_d    = infl_pc_q;
                v0_d       = 1'b1;
            end
        end

        if (issue) begin
            infl_pc_d = pc_q;
            pc_d      = pc_q + XLEN'(4);
        end

        // Redirect flushes the buffer and drops the outstanding response.
        if (bus.br_taken) begin
            v0_d   = 1'b0;
            v1_d   = 1'b0;
            infl_d = 1'b0;
            pc_d   = {bus.br_target[XLEN-1:2], 2'b00};
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            e0_instr_q <= '0;
            e0_pc_q    <= '0;
            e1_instr_q <= '0;
            e1_pc_q    <= '0;
            v0_q       <= 1'b0;
            v1_q       <= 1'b0;
            infl_q     <= 1'b0;
            infl_pc_q  <= '0;
        end else begin
            pc_q       <= pc_d;
            e0_instr_q <= e0_instr_d;
            e0_pc_q    <= e0_pc_d;
            e1_instr_q <= e1_instr_d;
            e1_pc_q    <= e1_pc_d;
            v0_q       <= v0_d;
            v1_q       <= v1_d;
            infl_q     <= infl_d;
            infl_pc_q  <= infl_pc_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [CW-1:0] fetched_q;
    logic [CW-1:0] stall_q;

    // Transfers (including one coinciding with a redirect) and stalled cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetched_q <= '0;
            stall_q   <= '0;
        end else begin
            if (pop) begin
                fetched_q <= fetched_q + CW'(1);
            end
            if (v0_q & ~bus.instr_ready) begin
                stall_q <= stall_q + CW'(1);
            end
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_stall   = stall_q;
`else
    assign perf_fetched = CW'(0);
    assign perf_stall   = CW'(0);
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit. A table drives the
// reset-release / stall sequence; hand-written sequences cover streaming,
// redirects and mid-stream reset. A scoreboard queue holds {pc, word} for
// every request seen and is checked on every transfer.
module tb_fetch_unit;
    localparam logic [63:0] RST_PC = 64'h0;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] word;
    } exp_t;

    typedef struct {
        logic        rdy;
        logic        exp_req;
        logic [63:0] exp_addr;
        logic        exp_valid;
        logic [63:0] exp_pc;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.master),
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    exp_t        sb_q[$];
    logic [31:0] m_fetched;
    logic [31:0] m_stall;

    logic        s_req;
    logic [63:0] s_addr;
    logic        s_valid;
    logic [63:0] s_pc;
    logic [31:0] s_instr;

    vec_t        vt[16];

    function automatic logic [31:0] imem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h0000_0013;
    endfunction

    // Instruction memory: word for the requested address, one cycle later.
    always @(posedge clk) begin
        bus.imem_rdata <= bus.imem_req ? imem_word(bus.imem_addr) : 32'hDEAD_BEEF;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, sample 1 time unit later, update scoreboard/model.
    task automatic step(input logic rdy, input logic br, input logic [63:0] tgt, input logic rst);
        exp_t e;
        @(negedge clk);
        reset           = rst;
        bus.instr_ready = rdy;
        bus.br_taken    = br;
        bus.br_target   = tgt;
        #1;
        s_req   = bus.imem_req;
        s_addr  = bus.imem_addr;
        s_valid = bus.instr_valid;
        s_pc    = bus.instr_pc;
        s_instr = bus.instr;
        if (rst) begin
            check("req_in_reset", 64'(s_req), 64'd0);
            sb_q.delete();
            m_fetched = '0;
            m_stall   = '0;
            return;
        end
`ifdef FETCH_PERF_EN
        check("perf_fetched", 64'(perf_fetched), 64'(m_fetched));
        check("perf_stall", 64'(perf_stall), 64'(m_stall));
`else
        check("perf_fetched_off", 64'(perf_fetched), 64'd0);
        check("perf_stall_off", 64'(perf_stall), 64'd0);
`endif
        if (s_valid && rdy) begin
            if (sb_q.size() == 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL sb_pop: transfer of pc 0x%0h with no outstanding request", s_pc);
            end else begin
                e = sb_q.pop_front();
                check("xfer_pc", s_pc, e.pc);
                check("xfer_instr", 64'(s_instr), 64'(e.word));
            end
            m_fetched = m_fetched + 32'd1;
        end
        if (s_valid && !rdy) m_stall = m_stall + 32'd1;
        if (br) begin
            check("req_on_branch", 64'(s_req), 64'd0);
            sb_q.delete();
        end
        if (s_req) sb_q.push_back('{pc: s_addr, word: imem_word(s_addr)});
    endtask

    task automatic expect_head(input string name, input logic v, input logic [63:0] pc);
        check({name, "_valid"}, 64'(s_valid), 64'(v));
        if (v) check({name, "_pc"}, s_pc, pc);
    endtask

    task automatic expect_req(input string name, input logic r, input logic [63:0] a);
        check({name, "_req"}, 64'(s_req), 64'(r));
        if (r) check({name, "_addr"}, s_addr, a);
    endtask

    initial begin
        reset           = 1'b1;
        bus.instr_ready = 1'b0;
        bus.br_taken    = 1'b0;
        bus.br_target   = 64'd0;
        m_fetched       = '0;
        m_stall         = '0;

        // Reset release, one pop, then ten stalled cycles, then streaming.
        vt[0]  = '{rdy: 1'b1, exp_req: 1'b1, exp_addr: 64'h0,  exp_valid: 1'b0, exp_pc: 64'h0};
        vt[1]  = '{rdy: 1'b1, exp_req: 1'b1, exp_addr: 64'h4,  exp_valid: 1'b0, exp_pc: 64'h0};
        vt[2]  = '{rdy: 1'b1, exp_req: 1'b1, exp_addr: 64'h8,  exp_valid: 1'b1, exp_pc: 64'h0};
        for (int i = 3; i <= 12; i++)
            vt[i] = '{rdy: 1'b0, exp_req: 1'b0, exp_addr: 64'h0, exp_valid: 1'b1, exp_pc: 64'h4};
        vt[13] = '{rdy: 1'b1, exp_req: 1'b1, exp_addr: 64'hC,  exp_valid: 1'b1, exp_pc: 64'h4};
        vt[14] = '{rdy: 1'b1, exp_req: 1'b1, exp_addr: 64'h10, exp_valid: 1'b1, exp_pc: 64'h8};
        vt[15] = '{rdy: 1'b1, exp_req: 1'b1, exp_addr: 64'h14, exp_valid: 1'b1, exp_pc: 64'hC};

        step(1'b1, 1'b0, 64'd0, 1'b1);
        step(1'b1, 1'b0, 64'd0, 1'b1);

        for (int i = 0; i < 16; i++) begin
            step(vt[i].rdy, 1'b0, 64'd0, 1'b0);
            check($sformatf("tbl%0d_req", i), 64'(s_req), 64'(vt[i].exp_req));
            if (vt[i].exp_req) check($sformatf("tbl%0d_addr", i), s_addr, vt[i].exp_addr);
            check($sformatf("tbl%0d_valid", i), 64'(s_valid), 64'(vt[i].exp_valid));
            check($sformatf("tbl%0d_pc", i), s_pc, vt[i].exp_pc);
            if (!vt[i].exp_valid) check($sformatf("tbl%0d_instr_zero", i), 64'(s_instr), 64'd0);
        end

        // Steady state at one buffered entry: push and pop every cycle.
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b0, 64'd0, 1'b0);
            expect_head($sformatf("stream%0d", k), 1'b1, 64'(16 + 4 * k));
            expect_req($sformatf("stream%0d", k), 1'b1, 64'(24 + 4 * k));
        end

        // Redirect with one buffered, one in flight, and a coinciding pop.
        step(1'b1, 1'b1, 64'h1002, 1'b0);
        expect_head("br1_cyc", 1'b1, 64'd96);
        step(1'b1, 1'b0, 64'd0, 1'b0);
        expect_head("br1_n1", 1'b0, 64'd0);
        expect_req("br1_n1", 1'b1, 64'h1000);
        step(1'b1, 1'b0, 64'd0, 1'b0);
        expect_head("br1_n2", 1'b0, 64'd0);
        expect_req("br1_n2", 1'b1, 64'h1004);
        step(1'b1, 1'b0, 64'd0, 1'b0);
        expect_head("br1_n3", 1'b1, 64'h1000);

        // Back-to-back redirects: the last target wins.
        step(1'b1, 1'b1, 64'h2000, 1'b0);
        step(1'b1, 1'b1, 64'h3007, 1'b0);
        step(1'b1, 1'b0, 64'd0, 1'b0);
        expect_head("br2_n1", 1'b0, 64'd0);
        expect_req("br2_n1", 1'b1, 64'h3004);
        step(1'b1, 1'b0, 64'd0, 1'b0);
        step(1'b1, 1'b0, 64'd0, 1'b0);
        expect_head("br2_n3", 1'b1, 64'h3004);

        // Fill the buffer, then redirect while full.
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 64'd0, 1'b0);
            if (k > 0) expect_req($sformatf("full%0d", k), 1'b0, 64'd0);
        end
        step(1'b0, 1'b1, 64'h4000, 1'b0);
        expect_head("br3_cyc", 1'b1, 64'h3008);
        step(1'b1, 1'b0, 64'd0, 1'b0);
        expect_head("br3_n1", 1'b0, 64'd0);
        expect_req("br3_n1", 1'b1, 64'h4000);
        step(1'b1, 1'b0, 64'd0, 1'b0);
        step(1'b1, 1'b0, 64'd0, 1'b0);
        expect_head("br3_n3", 1'b1, 64'h4000);

        // One-cycle reset mid-stream: buffer and stale response dropped.
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 64'd0, 1'b0);
        step(1'b1, 1'b0, 64'd0, 1'b1);
        step(1'b1, 1'b0, 64'd0, 1'b0);
        expect_head("rst_n1", 1'b0, 64'd0);
        expect_req("rst_n1", 1'b1, RST_PC);
        step(1'b1, 1'b0, 64'd0, 1'b0);
        expect_head("rst_n2", 1'b0, 64'd0);
        expect_req("rst_n2", 1'b1, RST_PC + 64'd4);
        step(1'b1, 1'b0, 64'd0, 1'b0);
        expect_head("rst_n3", 1'b1, RST_PC);

        // Counters: five transfers and three stalled cycles after a fresh reset.
        step(1'b1, 1'b0, 64'd0, 1'b1);
        step(1'b1, 1'b0, 64'd0, 1'b0);
        step(1'b1, 1'b0, 64'd0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 64'd0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 64'd0, 1'b0);
        for (int k = 0; k < 2; k++) step(1'b1, 1'b0, 64'd0, 1'b0);
        step(1'b0, 1'b0, 64'd0, 1'b0);
`ifdef FETCH_PERF_EN
        check("perf_fetched_5", 64'(perf_fetched), 64'd5);
        check("perf_stall_3", 64'(perf_stall), 64'd3);
`else
        check("perf_fetched_tied", 64'(perf_fetched), 64'd0);
        check("perf_stall_tied", 64'(perf_stall), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
